// File: rtl/fb_access_arbiter_pkg.sv
// Shared constants, bus state encoding and SRAM address packing for the frame-buffer arbiter.
package fb_pkg;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 20;

  // Raster geometry kept at 10 bits so comparisons against DrawX/DrawY stay width-matched.
  localparam logic [9:0] H_TOTAL = 10'd800;
  localparam logic [9:0] V_TOTAL = 10'd525;
  localparam logic [9:0] H_VIS   = 10'd640;
  localparam logic [9:0] V_VIS   = 10'd480;

  localparam logic [9:0] H_LAST     = H_TOTAL - 10'd1;
  localparam logic [9:0] V_LAST     = V_TOTAL - 10'd1;
  localparam logic [9:0] H_WR_LIMIT = H_TOTAL - 10'd2;

  typedef enum logic [1:0] {
    BUS_IDLE = 2'd0,
    BUS_RD   = 2'd1,
    BUS_WR   = 2'd2
  } bus_state_t;

  function automatic logic [ADDR_W-1:0] fb_addr(input logic page,
                                                input logic [9:0] x,
                                                input logic [9:0] y);
    return {page, y[8:0], x};
  endfunction

endpackage

// File: rtl/fb_swap_sequencer.sv
// Double-buffer page ownership: latches a swap request and flips the displayed page at end of frame.
module fb_swap_sequencer
  import fb_pkg::*;
(
  input  logic       VGA_CLK,
  input  logic       RESET,
  input  logic [9:0] draw_x_i,
  input  logic [9:0] draw_y_i,
  input  logic       draw_done_i,
  output logic       page_sel_o,
  output logic       swap_pending_o,
  output logic       swap_ack_o
);

  logic page_q, page_d;
  logic pending_q, pending_d;
  logic ack_q, ack_d;
  logic end_of_frame;

  assign end_of_frame = (draw_x_i == H_LAST) && (draw_y_i == V_LAST);

  // A DRAW_DONE landing on the very last pixel still counts for this frame's swap.
  always_comb begin
    page_d    = page_q;
    pending_d = pending_q;
    ack_d     = 1'b0;
    if (end_of_frame && (pending_q || draw_done_i)) begin
      page_d    = ~page_q;
      pending_d = 1'b0;
      ack_d     = 1'b1;
    end else if (draw_done_i) begin
      pending_d = 1'b1;
    end
  end

  always_ff @(posedge VGA_CLK or posedge RESET) begin
    if (RESET) begin
      page_q    <= 1'b0;
      pending_q <= 1'b0;
      ack_q     <= 1'b0;
    end else begin
      page_q    <= page_d;
      pending_q <= pending_d;
      ack_q     <= ack_d;
    end
  end

  assign page_sel_o     = page_q;
  assign swap_pending_o = pending_q;
  assign swap_ack_o     = ack_q;

endmodule

// File: rtl/fb_access_arbiter.sv
// Single-port SRAM frame-buffer arbiter: display reads win in the visible area, draw writes use blanking.
// Optional out-of-range write counter is built when FB_DROP_COUNT_EN is defined.
module fb_access_arbiter
  import fb_pkg::*;
(
  input  logic              VGA_CLK,
  input  logic              RESET,
  input  logic [9:0]        DrawX,
  input  logic [9:0]        DrawY,
  input  logic              WR_VALID,
  output logic              WR_READY,
  input  logic [9:0]        WR_X,
  input  logic [9:0]        WR_Y,
  input  logic [DATA_W-1:0] WR_DATA,
  input  logic              DRAW_DONE,
  output logic              SWAP_ACK,
  output logic              PAGE_SEL,
  output logic [ADDR_W-1:0] SRAM_ADDR,
  output logic              SRAM_WE_N,
  output logic              SRAM_OE_N,
  output logic [DATA_W-1:0] SRAM_DQ_OUT,
  output logic              SRAM_DQ_OE,
  input  logic [DATA_W-1:0] SRAM_DQ_IN,
  output logic [DATA_W-1:0] PIXEL_DATA,
  output logic              PIXEL_VALID,
  output logic [15:0]       DROP_COUNT
);

  logic page_sel, swap_pending;

  fb_swap_sequencer u_swap (
    .VGA_CLK        (VGA_CLK),
    .RESET          (RESET),
    .draw_x_i       (DrawX),
    .draw_y_i       (DrawY),
    .draw_done_i    (DRAW_DONE),
    .page_sel_o     (page_sel),
    .swap_pending_o (swap_pending),
    .swap_ack_o     (SWAP_ACK)
  );

  assign PAGE_SEL = page_sel;

  logic visible, wr_in_range, wr_fire;

  assign visible     = (DrawX < H_VIS) && (DrawY < V_VIS);
  assign wr_in_range = (WR_X < H_VIS) && (WR_Y < V_VIS);

  // Handshake: a write transfers on any rising edge where WR_VALID && WR_READY; WR_READY
  // never depends on WR_VALID. The column exclusions keep an idle bus cycle at both turnarounds.
  assign WR_READY = ~RESET & ~visible & ~swap_pending & (DrawX != H_VIS) & (DrawX < H_WR_LIMIT);
  assign wr_fire  = WR_VALID & WR_READY;

  bus_state_t          bus_state_q, bus_state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   dq_out_q, dq_out_d;
  logic                we_n_q, oe_n_q, dq_oe_q;
  logic [DATA_W-1:0]   pixel_data_q;
  logic                pixel_valid_q;

  always_comb begin
    bus_state_d = BUS_IDLE;
    addr_d      = addr_q;
    dq_out_d    = dq_out_q;
    if (visible) begin
      bus_state_d = BUS_RD;
      addr_d      = fb_addr(page_sel, DrawX, DrawY);
    end else if (wr_fire && wr_in_range) begin
      bus_state_d = BUS_WR;
      addr_d      = fb_addr(~page_sel, WR_X, WR_Y);
      dq_out_d    = WR_DATA;
    end
  end

  // SRAM strobes are registered straight from the next state so the pins never glitch.
  always_ff @(posedge VGA_CLK or posedge RESET) begin
    if (RESET) begin
      bus_state_q <= BUS_IDLE;
      addr_q      <= '0;
      dq_out_q    <= '0;
      we_n_q      <= 1'b1;
      oe_n_q      <= 1'b1;
      dq_oe_q     <= 1'b0;
    end else begin
      bus_state_q <= bus_state_d;
      addr_q      <= addr_d;
      dq_out_q    <= dq_out_d;
      we_n_q      <= (bus_state_d != BUS_WR);
      oe_n_q      <= (bus_state_d != BUS_RD);
      dq_oe_q     <= (bus_state_d == BUS_WR);
    end
  end

  always_ff @(posedge VGA_CLK or posedge RESET) begin
    if (RESET) begin
      pixel_data_q  <= '0;
      pixel_valid_q <= 1'b0;
    end else begin
      pixel_valid_q <= (bus_state_q == BUS_RD);
      if (bus_state_q == BUS_RD) pixel_data_q <= SRAM_DQ_IN;
    end
  end

  assign SRAM_ADDR   = addr_q;
  assign SRAM_DQ_OUT = dq_out_q;
  assign SRAM_WE_N   = we_n_q;
  assign SRAM_OE_N   = oe_n_q;
  assign SRAM_DQ_OE  = dq_oe_q;
  assign PIXEL_DATA  = pixel_data_q;
  assign PIXEL_VALID = pixel_valid_q;

`ifdef FB_DROP_COUNT_EN
  logic [15:0] drop_q, drop_d;

  always_comb begin
    drop_d = drop_q;
    if (wr_fire && !wr_in_range && (drop_q != 16'hFFFF)) drop_d = drop_q + 16'd1;
  end

  always_ff @(posedge VGA_CLK or posedge RESET) begin
    if (RESET) drop_q <= 16'd0;
    else       drop_q <= drop_d;
  end

  assign DROP_COUNT = drop_q;
`else
  assign DROP_COUNT = 16'd0;
`endif

endmodule

// File: tb/tb_fb_access_arbiter.sv
// Directed bench for fb_access_arbiter: reset, read pipeline, blanking writes, turnaround and page swap.
module tb_fb_access_arbiter;
  import fb_pkg::*;

  logic              VGA_CLK;
  logic              RESET;
  logic [9:0]        DrawX, DrawY;
  logic              WR_VALID;
  logic              WR_READY;
  logic [9:0]        WR_X, WR_Y;
  logic [DATA_W-1:0] WR_DATA;
  logic              DRAW_DONE;
  logic              SWAP_ACK;
  logic              PAGE_SEL;
  logic [ADDR_W-1:0] SRAM_ADDR;
  logic              SRAM_WE_N, SRAM_OE_N, SRAM_DQ_OE;
  logic [DATA_W-1:0] SRAM_DQ_OUT, SRAM_DQ_IN;
  logic [DATA_W-1:0] PIXEL_DATA;
  logic              PIXEL_VALID;
  logic [15:0]       DROP_COUNT;

  int vec_cnt = 0;
  int err_cnt = 0;
  logic [DATA_W-1:0] exp_q[$];

`ifdef FB_DROP_COUNT_EN
  localparam logic [15:0] EXP_DROP = 16'd3;
`else
  localparam logic [15:0] EXP_DROP = 16'd0;
`endif

  fb_access_arbiter dut (
    .VGA_CLK     (VGA_CLK),
    .RESET       (RESET),
    .DrawX       (DrawX),
    .DrawY       (DrawY),
    .WR_VALID    (WR_VALID),
    .WR_READY    (WR_READY),
    .WR_X        (WR_X),
    .WR_Y        (WR_Y),
    .WR_DATA     (WR_DATA),
    .DRAW_DONE   (DRAW_DONE),
    .SWAP_ACK    (SWAP_ACK),
    .PAGE_SEL    (PAGE_SEL),
    .SRAM_ADDR   (SRAM_ADDR),
    .SRAM_WE_N   (SRAM_WE_N),
    .SRAM_OE_N   (SRAM_OE_N),
    .SRAM_DQ_OUT (SRAM_DQ_OUT),
    .SRAM_DQ_OE  (SRAM_DQ_OE),
    .SRAM_DQ_IN  (SRAM_DQ_IN),
    .PIXEL_DATA  (PIXEL_DATA),
    .PIXEL_VALID (PIXEL_VALID),
    .DROP_COUNT  (DROP_COUNT)
  );

  // clock / reset
  initial VGA_CLK = 1'b0;
  always #5 VGA_CLK = ~VGA_CLK;

  // Inputs change on the falling edge; registered outputs seen here belong to the previous decision.
  task automatic drive(input logic [9:0] x, input logic [9:0] y);
    @(negedge VGA_CLK);
    DrawX = x;
    DrawY = y;
    #1;
  endtask

  task automatic set_write(input logic v, input logic [9:0] x, input logic [9:0] y, input logic [15:0] d);
    WR_VALID = v;
    WR_X     = x;
    WR_Y     = y;
    WR_DATA  = d;
  endtask

  task automatic test_reset;
    drive(10'd700, 10'd100);
    vec_cnt++; if (SRAM_WE_N !== 1'b1) begin err_cnt++; $display("FAIL rst_we_n: got %b want 1", SRAM_WE_N); end
    vec_cnt++; if (SRAM_OE_N !== 1'b1) begin err_cnt++; $display("FAIL rst_oe_n: got %b want 1", SRAM_OE_N); end
    vec_cnt++; if (SRAM_DQ_OE !== 1'b0) begin err_cnt++; $display("FAIL rst_dq_oe: got %b want 0", SRAM_DQ_OE); end
    vec_cnt++; if (SRAM_ADDR !== 20'h00000) begin err_cnt++; $display("FAIL rst_addr: got %h want 00000", SRAM_ADDR); end
    vec_cnt++; if (SRAM_DQ_OUT !== 16'h0000) begin err_cnt++; $display("FAIL rst_dq_out: got %h want 0000", SRAM_DQ_OUT); end
    vec_cnt++; if (PIXEL_DATA !== 16'h0000 || PIXEL_VALID !== 1'b0) begin err_cnt++; $display("FAIL rst_pixel: got %h/%b want 0000/0", PIXEL_DATA, PIXEL_VALID); end
    vec_cnt++; if (PAGE_SEL !== 1'b0 || SWAP_ACK !== 1'b0) begin err_cnt++; $display("FAIL rst_swap: got page %b ack %b want 0/0", PAGE_SEL, SWAP_ACK); end
    vec_cnt++; if (WR_READY !== 1'b0) begin err_cnt++; $display("FAIL rst_wr_ready: got %b want 0", WR_READY); end
    vec_cnt++; if (DROP_COUNT !== 16'd0) begin err_cnt++; $display("FAIL rst_drop: got %0d want 0", DROP_COUNT); end
    RESET = 1'b0;
    // Reset arriving while a display read is on the bus
    drive(10'd100, 10'd50);
    drive(10'd101, 10'd50);
    vec_cnt++; if (SRAM_OE_N !== 1'b0) begin err_cnt++; $display("FAIL pre_rst_rd: got oe_n %b want 0", SRAM_OE_N); end
    RESET = 1'b1;
    #1;
    vec_cnt++; if (SRAM_OE_N !== 1'b1 || PIXEL_VALID !== 1'b0 || PAGE_SEL !== 1'b0) begin err_cnt++; $display("FAIL rst_mid_rd: got oe_n %b pv %b page %b want 1/0/0", SRAM_OE_N, PIXEL_VALID, PAGE_SEL); end
    drive(10'd102, 10'd50);
    vec_cnt++; if (SRAM_OE_N !== 1'b1 || PIXEL_VALID !== 1'b0) begin err_cnt++; $display("FAIL rst_hold: got oe_n %b pv %b want 1/0", SRAM_OE_N, PIXEL_VALID); end
    // Reset arriving while a write is on the bus
    RESET = 1'b0;
    set_write(1'b1, 10'd10, 10'd3, 16'hBEEF);
    drive(10'd700, 10'd100);
    drive(10'd701, 10'd100);
    vec_cnt++; if (SRAM_WE_N !== 1'b0) begin err_cnt++; $display("FAIL pre_rst_wr: got we_n %b want 0", SRAM_WE_N); end
    RESET = 1'b1;
    #1;
    vec_cnt++; if (SRAM_WE_N !== 1'b1 || SRAM_DQ_OE !== 1'b0 || SRAM_ADDR !== 20'h0) begin err_cnt++; $display("FAIL rst_mid_wr: got we_n %b dq_oe %b addr %h want 1/0/00000", SRAM_WE_N, SRAM_DQ_OE, SRAM_ADDR); end
    set_write(1'b0, 10'd0, 10'd0, 16'h0);
    drive(10'd702, 10'd100);
    RESET = 1'b0;
  endtask

  task automatic test_read;
    drive(10'd5, 10'd7);
    drive(10'd700, 10'd7);
    vec_cnt++; if (SRAM_ADDR !== 20'h01C05 || SRAM_OE_N !== 1'b0 || SRAM_WE_N !== 1'b1) begin err_cnt++; $display("FAIL read_addr: got %h oe_n %b we_n %b want 01c05/0/1", SRAM_ADDR, SRAM_OE_N, SRAM_WE_N); end
    SRAM_DQ_IN = 16'hA5C3;
    drive(10'd701, 10'd7);
    SRAM_DQ_IN = 16'h0000;
    vec_cnt++; if (PIXEL_DATA !== 16'hA5C3 || PIXEL_VALID !== 1'b1) begin err_cnt++; $display("FAIL read_pixel: got %h/%b want a5c3/1", PIXEL_DATA, PIXEL_VALID); end
    vec_cnt++; if (SRAM_OE_N !== 1'b1) begin err_cnt++; $display("FAIL read_idle: got oe_n %b want 1", SRAM_OE_N); end
    drive(10'd702, 10'd7);
    vec_cnt++; if (PIXEL_VALID !== 1'b0) begin err_cnt++; $display("FAIL read_valid_drop: got %b want 0", PIXEL_VALID); end
  endtask

  // Four consecutive visible pixels; SRAM data for pixel k is supplied one cycle after it is presented.
  task automatic test_back_to_back;
    logic [DATA_W-1:0] exp_data;
    logic [ADDR_W-1:0] exp_addr;
    for (int c = 0; c < 6; c++) begin
      drive((c < 4) ? 10'(20 + c) : 10'd700, 10'd9);
      if (c >= 1 && c <= 4) begin
        exp_addr = 20'h02400 + 20'(20 + c - 1);
        vec_cnt++; if (SRAM_ADDR !== exp_addr || SRAM_OE_N !== 1'b0) begin err_cnt++; $display("FAIL b2b_addr[%0d]: got %h oe_n %b want %h/0", c, SRAM_ADDR, SRAM_OE_N, exp_addr); end
        SRAM_DQ_IN = 16'h1000 + 16'(c - 1) * 16'h0111;
        exp_q.push_back(SRAM_DQ_IN);
      end else begin
        SRAM_DQ_IN = 16'h0000;
      end
      if (c >= 2) begin
        exp_data = exp_q.pop_front();
        vec_cnt++; if (PIXEL_DATA !== exp_data || PIXEL_VALID !== 1'b1) begin err_cnt++; $display("FAIL b2b_pixel[%0d]: got %h/%b want %h/1", c, PIXEL_DATA, PIXEL_VALID, exp_data); end
      end
    end
    drive(10'd701, 10'd9);
    vec_cnt++; if (PIXEL_VALID !== 1'b0 || exp_q.size() != 0) begin err_cnt++; $display("FAIL b2b_end: got pv %b left %0d want 0/0", PIXEL_VALID, exp_q.size()); end
  endtask

  task automatic test_write;
    set_write(1'b1, 10'd10, 10'd3, 16'hBEEF);
    drive(10'd300, 10'd100);
    vec_cnt++; if (WR_READY !== 1'b0) begin err_cnt++; $display("FAIL wr_visible_ready: got %b want 0", WR_READY); end
    drive(10'd700, 10'd100);
    vec_cnt++; if (SRAM_OE_N !== 1'b0 || SRAM_WE_N !== 1'b1) begin err_cnt++; $display("FAIL wr_visible_bus: got oe_n %b we_n %b want 0/1", SRAM_OE_N, SRAM_WE_N); end
    vec_cnt++; if (WR_READY !== 1'b1) begin err_cnt++; $display("FAIL wr_blank_ready: got %b want 1", WR_READY); end
    drive(10'd750, 10'd100);
    set_write(1'b0, 10'd0, 10'd0, 16'h0);
    vec_cnt++; if (SRAM_WE_N !== 1'b0 || SRAM_DQ_OE !== 1'b1 || SRAM_OE_N !== 1'b1) begin err_cnt++; $display("FAIL wr_strobes: got we_n %b dq_oe %b oe_n %b want 0/1/1", SRAM_WE_N, SRAM_DQ_OE, SRAM_OE_N); end
    vec_cnt++; if (SRAM_ADDR !== 20'h80C0A || SRAM_DQ_OUT !== 16'hBEEF) begin err_cnt++; $display("FAIL wr_addr_data: got %h/%h want 80c0a/beef", SRAM_ADDR, SRAM_DQ_OUT); end
    drive(10'd751, 10'd100);
    vec_cnt++; if (SRAM_WE_N !== 1'b1 || SRAM_DQ_OE !== 1'b0) begin err_cnt++; $display("FAIL wr_release: got we_n %b dq_oe %b want 1/0", SRAM_WE_N, SRAM_DQ_OE); end
    drive(10'd100, 10'd480);
    vec_cnt++; if (WR_READY !== 1'b1) begin err_cnt++; $display("FAIL wr_vblank_ready: got %b want 1", WR_READY); end
  endtask

  task automatic test_blank_edges;
    set_write(1'b1, 10'd20, 10'd4, 16'h5A5A);
    drive(10'd640, 10'd100);
    vec_cnt++; if (WR_READY !== 1'b0) begin err_cnt++; $display("FAIL edge_640: got %b want 0", WR_READY); end
    drive(10'd798, 10'd100);
    vec_cnt++; if (WR_READY !== 1'b0) begin err_cnt++; $display("FAIL edge_798: got %b want 0", WR_READY); end
    drive(10'd799, 10'd100);
    vec_cnt++; if (WR_READY !== 1'b0) begin err_cnt++; $display("FAIL edge_799: got %b want 0", WR_READY); end
    drive(10'd797, 10'd100);
    vec_cnt++; if (WR_READY !== 1'b1) begin err_cnt++; $display("FAIL edge_797: got %b want 1", WR_READY); end
    drive(10'd798, 10'd100);
    vec_cnt++; if (SRAM_WE_N !== 1'b0 || SRAM_ADDR !== 20'h8100A + 20'h0000A) begin err_cnt++; $display("FAIL edge_wr_798: got we_n %b addr %h want 0/81014", SRAM_WE_N, SRAM_ADDR); end
    drive(10'd799, 10'd100);
    vec_cnt++; if (SRAM_WE_N !== 1'b1 || SRAM_OE_N !== 1'b1) begin err_cnt++; $display("FAIL edge_idle_799: got we_n %b oe_n %b want 1/1", SRAM_WE_N, SRAM_OE_N); end
    drive(10'd0, 10'd101);
    vec_cnt++; if (SRAM_WE_N !== 1'b1 || SRAM_OE_N !== 1'b1) begin err_cnt++; $display("FAIL edge_idle_0: got we_n %b oe_n %b want 1/1", SRAM_WE_N, SRAM_OE_N); end
    drive(10'd1, 10'd101);
    set_write(1'b0, 10'd0, 10'd0, 16'h0);
    vec_cnt++; if (SRAM_OE_N !== 1'b0 || SRAM_WE_N !== 1'b1) begin err_cnt++; $display("FAIL edge_rd_1: got oe_n %b we_n %b want 0/1", SRAM_OE_N, SRAM_WE_N); end
  endtask

  task automatic test_drop;
    set_write(1'b1, 10'd640, 10'd0, 16'h1111);
    for (int i = 0; i < 4; i++) begin
      drive(10'(700 + i), 10'd100);
      if (i == 3) set_write(1'b0, 10'd0, 10'd0, 16'h0);
      else begin
        vec_cnt++; if (WR_READY !== 1'b1) begin err_cnt++; $display("FAIL drop_ready[%0d]: got %b want 1", i, WR_READY); end
      end
      vec_cnt++; if (SRAM_WE_N !== 1'b1) begin err_cnt++; $display("FAIL drop_we_n[%0d]: got %b want 1", i, SRAM_WE_N); end
    end
    vec_cnt++; if (DROP_COUNT !== EXP_DROP) begin err_cnt++; $display("FAIL drop_count: got %0d want %0d", DROP_COUNT, EXP_DROP); end
  endtask

  task automatic test_swap;
    set_write(1'b1, 10'd10, 10'd3, 16'h2222);
    drive(10'd700, 10'd299);
    vec_cnt++; if (WR_READY !== 1'b1) begin err_cnt++; $display("FAIL swap_base_ready: got %b want 1", WR_READY); end
    drive(10'd0, 10'd300);
    DRAW_DONE = 1'b1;
    drive(10'd1, 10'd300);
    DRAW_DONE = 1'b0;
    drive(10'd700, 10'd300);
    vec_cnt++; if (WR_READY !== 1'b0 || PAGE_SEL !== 1'b0) begin err_cnt++; $display("FAIL swap_pending_ready: got %b page %b want 0/0", WR_READY, PAGE_SEL); end
    // A second request while already pending must not cause a second flip later
    drive(10'd0, 10'd301);
    DRAW_DONE = 1'b1;
    drive(10'd1, 10'd301);
    DRAW_DONE = 1'b0;
    drive(10'd700, 10'd480);
    vec_cnt++; if (WR_READY !== 1'b0) begin err_cnt++; $display("FAIL swap_vblank_ready: got %b want 0", WR_READY); end
    drive(10'd799, 10'd524);
    vec_cnt++; if (PAGE_SEL !== 1'b0 || SRAM_WE_N !== 1'b1) begin err_cnt++; $display("FAIL swap_before_eof: got page %b we_n %b want 0/1", PAGE_SEL, SRAM_WE_N); end
    drive(10'd0, 10'd0);
    vec_cnt++; if (PAGE_SEL !== 1'b1 || SWAP_ACK !== 1'b1) begin err_cnt++; $display("FAIL swap_flip: got page %b ack %b want 1/1", PAGE_SEL, SWAP_ACK); end
    drive(10'd1, 10'd0);
    vec_cnt++; if (PAGE_SEL !== 1'b1 || SWAP_ACK !== 1'b0) begin err_cnt++; $display("FAIL swap_ack_pulse: got page %b ack %b want 1/0", PAGE_SEL, SWAP_ACK); end
    drive(10'd700, 10'd0);
    vec_cnt++; if (WR_READY !== 1'b1) begin err_cnt++; $display("FAIL swap_ready_back: got %b want 1", WR_READY); end
    drive(10'd701, 10'd0);
    set_write(1'b0, 10'd0, 10'd0, 16'h0);
    vec_cnt++; if (SRAM_WE_N !== 1'b0 || SRAM_ADDR !== 20'h00C0A || SRAM_DQ_OUT !== 16'h2222) begin err_cnt++; $display("FAIL swap_wr_page0: got we_n %b addr %h dq %h want 0/00c0a/2222", SRAM_WE_N, SRAM_ADDR, SRAM_DQ_OUT); end
    drive(10'd5, 10'd7);
    drive(10'd700, 10'd7);
    vec_cnt++; if (SRAM_ADDR !== 20'h81C05 || SRAM_OE_N !== 1'b0) begin err_cnt++; $display("FAIL swap_rd_page1: got %h oe_n %b want 81c05/0", SRAM_ADDR, SRAM_OE_N); end
    // Frame with no request: page stays
    drive(10'd799, 10'd524);
    drive(10'd0, 10'd0);
    vec_cnt++; if (PAGE_SEL !== 1'b1 || SWAP_ACK !== 1'b0) begin err_cnt++; $display("FAIL swap_hold: got page %b ack %b want 1/0", PAGE_SEL, SWAP_ACK); end
    // Request arriving on the last pixel itself
    drive(10'd799, 10'd524);
    DRAW_DONE = 1'b1;
    drive(10'd0, 10'd0);
    DRAW_DONE = 1'b0;
    vec_cnt++; if (PAGE_SEL !== 1'b0 || SWAP_ACK !== 1'b1) begin err_cnt++; $display("FAIL swap_same_cycle: got page %b ack %b want 0/1", PAGE_SEL, SWAP_ACK); end
    drive(10'd700, 10'd0);
    vec_cnt++; if (WR_READY !== 1'b1 || SWAP_ACK !== 1'b0) begin err_cnt++; $display("FAIL swap_same_cycle_clear: got ready %b ack %b want 1/0", WR_READY, SWAP_ACK); end
  endtask

  initial begin
    RESET      = 1'b1;
    DrawX      = 10'd0;
    DrawY      = 10'd0;
    DRAW_DONE  = 1'b0;
    SRAM_DQ_IN = 16'h0000;
    set_write(1'b0, 10'd0, 10'd0, 16'h0);
    test_reset();
    test_read();
    test_back_to_back();
    test_write();
    test_blank_edges();
    test_drop();
    test_swap();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule

// File: doc/fb_access_arbiter.md
Name: fb_access_arbiter

Overview:
- Shares the single-port SRAM frame buffer between two requesters: the VGA display read path (hard priority, one read per visible pixel) and the draw engine write path (valid/ready handshake, served only in blanking).
- Owns double-buffer page selection: the display reads page PAGE_SEL and the draw engine writes page ~PAGE_SEL.
- Swaps pages only at end of frame, and only after the draw engine declares its frame complete.
- Sits between the VGA timing generator (DrawX/DrawY) and the SRAM pins.

Parameters:
- H_TOTAL, 800, pixels per raster line including blanking
- V_TOTAL, 525, lines per frame including blanking
- H_VIS, 640, visible pixels per line
- V_VIS, 480, visible lines
- DATA_W, 16, pixel/SRAM word width
- ADDR_W, 20, SRAM address width; address = {page, y[8:0], x[9:0]}

Ports:
- VGA_CLK  in  1  pixel clock; all logic on rising edge
- RESET  in  1  asynchronous, active-high reset
- DrawX  in  10  current raster X
- DrawY  in  10  current raster Y
- WR_VALID  in  1  draw engine write request
- WR_READY  out  1  arbiter accepts write this cycle
- WR_X  in  10  write pixel X
- WR_Y  in  10  write pixel Y
- WR_DATA  in  DATA_W  write pixel value
- DRAW_DONE  in  1  one-cycle pulse: back page complete, request swap
- SWAP_ACK  out  1  one-cycle pulse when the swap takes effect
- PAGE_SEL  out  1  page currently displayed
- SRAM_ADDR  out  ADDR_W  registered SRAM address
- SRAM_WE_N  out  1  registered write enable, active low
- SRAM_OE_N  out  1  registered output enable, active low
- SRAM_DQ_OUT  out  DATA_W  write data
- SRAM_DQ_OE  out  1  tristate enable for SRAM_DQ_OUT
- SRAM_DQ_IN  in  DATA_W  read data from SRAM
- PIXEL_DATA  out  DATA_W  display pixel
- PIXEL_VALID  out  1  PIXEL_DATA corresponds to a visible pixel
- DROP_COUNT  out  16  out-of-range write count (see Optional Feature)

Behaviour:
- Reset values: PAGE_SEL=0, swap_pending=0, SWAP_ACK=0, WR_READY=0, SRAM_WE_N=1, SRAM_OE_N=1, SRAM_DQ_OE=0, SRAM_ADDR=0, SRAM_DQ_OUT=0, PIXEL_DATA=0, PIXEL_VALID=0, bus state IDLE.
- Reset mid-operation aborts any in-flight access immediately; no SRAM write may complete after RESET rises.
- Bus FSM state is the SRAM activity in the current cycle:
  - IDLE: OE_N=1, WE_N=1, DQ_OE=0
  - RD: OE_N=0, addr={PAGE_SEL, DrawY[8:0], DrawX[9:0]} as sampled the previous cycle
  - WR: WE_N=0, DQ_OE=1, addr={~PAGE_SEL, WR_Y[8:0], WR_X[9:0]}
- Next state is decided from cycle-t inputs and registered at the end of t:
  - RD if DrawX<H_VIS and DrawY<V_VIS
  - otherwise WR if WR_VALID && WR_READY && write in range
  - otherwise IDLE
- Read latency: pixel (x,y) presented at cycle t; SRAM_DQ_IN sampled at end of t+1; PIXEL_DATA/PIXEL_VALID valid in cycle t+2. The downstream pipeline compensates with a fixed 2-cycle delay.
- WR_READY (combinational, registered-free) = ~(DrawX<H_VIS && DrawY<V_VIS) && ~swap_pending && DrawX!=H_VIS && DrawX<H_TOTAL-2.
  - This guarantees at least one IDLE cycle at every RD-to-WR and WR-to-RD bus turnaround.
- Out-of-range write (WR_X>=H_VIS or WR_Y>=V_VIS) still handshakes but produces IDLE; WE_N stays 1.
- Swap sequencing:
  - DRAW_DONE sets swap_pending.
  - At DrawX==H_TOTAL-1 && DrawY==V_TOTAL-1 with swap_pending (including DRAW_DONE in that same cycle): toggle PAGE_SEL, clear swap_pending, pulse SWAP_ACK for 1 cycle.
  - Without swap_pending, the current page is displayed again and PAGE_SEL is unchanged.
  - DRAW_DONE while already pending has no additional effect.
- WR_READY stays 0 from DRAW_DONE until SWAP_ACK, so no write can land on a page that is about to be displayed.

Optional Feature:
- Macro FB_DROP_COUNT_EN.
- Defined: DROP_COUNT increments on each accepted out-of-range write and saturates at 16'hFFFF. It is cleared by RESET only.
- Undefined: DROP_COUNT is tied to 0 and no counter logic is built.

Decomposition:
- Package fb_pkg holds:
  - localparams H_TOTAL/V_TOTAL/H_VIS/V_VIS defaults
  - typedef enum logic [1:0] {BUS_IDLE, BUS_RD, BUS_WR} bus_state_t
  - function fb_addr(page, x, y) returning ADDR_W bits
- One natural sub-module, fb_swap_sequencer, owning swap_pending, PAGE_SEL and SWAP_ACK.

Test Plan:
- Reset asserted mid-frame at DrawX=100, DrawY=50 → next cycle all SRAM controls inactive, PAGE_SEL=0, PIXEL_VALID=0.
- Visible pixel (5,7), PAGE_SEL=0 → cycle t+1: SRAM_ADDR=0x01C05, OE_N=0; cycle t+2: PIXEL_DATA = SRAM_DQ_IN sampled at t+1, PIXEL_VALID=1.
- WR_VALID held with (10,3,0xBEEF) during DrawX=300, DrawY=100 → WR_READY=0. Repeat at DrawX=700, DrawY=100 → accepted; next cycle WE_N=0, addr=0x80C0A, DQ_OUT=0xBEEF, DQ_OE=1.
- Write requested at DrawX=640, 798 and 799 → WR_READY=0 for all three. WR_READY=1 at DrawX=797; the resulting WR falls at 798, leaving DrawX=799 and 0 IDLE before RD.
- DRAW_DONE pulse at line 300 → WR_READY=0 until end of frame; at (799,524) PAGE_SEL 0→1 with a 1-cycle SWAP_ACK. With no DRAW_DONE in the next frame, PAGE_SEL holds 1.
- With FB_DROP_COUNT_EN defined, three writes to (640,0) → DROP_COUNT=3 and WE_N stays 1 throughout.
